// File: rtl/des_rk_buffer.sv
// des_rk_buffer: steps the DES key schedule (ks) through rounds 1..16 and
// buffers the 16 round keys for indexed reads in encrypt or decrypt order.
module des_rk_buffer #(
  parameter int KEY_W  = 64,
  parameter int RK_W   = 48,
  parameter int ROUNDS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_load,
  input  logic [KEY_W-1:0]           key_in,
  output logic                       load_ignored,
  output logic                       key_busy,
  output logic                       keys_ready,
  output logic                       ks_start,
  output logic [KEY_W-1:0]           ks_key,
  output logic [4:0]                 ks_round_num,
  input  logic [RK_W-1:0]            ks_round_key,
  input  logic                       req_valid,
  input  logic                       req_decrypt,
  input  logic [$clog2(ROUNDS)-1:0]  req_round,
  output logic                       rsp_valid,
  output logic [RK_W-1:0]            rsp_key
);

  // state     | meaning
  // S_IDLE    | no valid keys, waiting for key_load
  // S_START   | one-cycle ks_start pulse, ks loads the key
  // S_CAPTURE | one round key captured per cycle into slot (ROUNDS-1-rem)
  // S_READY   | all round keys valid, read requests served

  localparam int IDX_W = $clog2(ROUNDS);
  localparam int RN_W  = 5;

  typedef enum logic [1:0] {S_IDLE, S_START, S_CAPTURE, S_READY} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  rem, rem_nxt;
  logic [IDX_W-1:0]  slot, slot_nxt, req_slot;
  logic              busy_state, load_ok, req_ok;
  logic [RK_W-1:0]   rk_buf [ROUNDS];

  assign busy_state = (state == S_START) || (state == S_CAPTURE);
  assign load_ok    = key_load && ((state == S_IDLE) || (state == S_READY));
  assign req_ok     = req_valid && keys_ready;
  assign slot       = IDX_W'(ROUNDS - 1) - rem;
  assign slot_nxt   = IDX_W'(ROUNDS - 1) - rem_nxt;
  assign req_slot   = req_decrypt ? IDX_W'(ROUNDS - 1) - req_round : req_round;

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    case (state)
      S_IDLE, S_READY: begin
        if (key_load) state_nxt = S_START;
      end
      S_START: begin
        state_nxt = S_CAPTURE;
        rem_nxt   = IDX_W'(ROUNDS - 1);
      end
      S_CAPTURE: begin
        if (rem == '0) state_nxt = S_READY;
        else           rem_nxt   = rem - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rem          <= '0;
      ks_start     <= 1'b0;
      ks_round_num <= '0;
      ks_key       <= '0;
      keys_ready   <= 1'b0;
      key_busy     <= 1'b0;
      load_ignored <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_key      <= '0;
    end else begin
      state        <= state_nxt;
      rem          <= rem_nxt;
      ks_start     <= (state_nxt == S_START);
      ks_round_num <= ((state_nxt == S_CAPTURE) && (rem_nxt != '0)) ?
                      RN_W'(slot_nxt) + RN_W'(1) : '0;
      keys_ready   <= (state_nxt == S_READY);
      key_busy     <= (state_nxt == S_START) || (state_nxt == S_CAPTURE);
      load_ignored <= key_load && busy_state;
      if (load_ok) ks_key <= key_in;
      rsp_valid    <= req_ok;
      if (req_ok) rsp_key <= rk_buf[req_slot];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state == S_CAPTURE)) rk_buf[slot] <= ks_round_key;
  end

endmodule

// File: tb/tb_des_rk_buffer.sv
// Bench for des_rk_buffer: a stand-in ks model feeds round keys, and a per-slot
// key array predicts every response and the load/capture timing.
module tb_des_rk_buffer;

  localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] KNOWN_K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] KNOWN_K16 = 48'hCB3D8B0E17F5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_load = 1'b0;
  logic [63:0] key_in = '0;
  logic        load_ignored, key_busy, keys_ready, ks_start;
  logic [63:0] ks_key;
  logic [4:0]  ks_round_num;
  logic [47:0] ks_round_key;
  logic        req_valid = 1'b0;
  logic        req_decrypt = 1'b0;
  logic [3:0]  req_round = '0;
  logic        rsp_valid;
  logic [47:0] rsp_key;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_rsp = 0;
  logic [47:0] model_keys [16];
  bit          model_ready = 1'b0;
  logic [47:0] exp_rsp = '0;

  des_rk_buffer dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .load_ignored(load_ignored), .key_busy(key_busy), .keys_ready(keys_ready),
    .ks_start(ks_start), .ks_key(ks_key), .ks_round_num(ks_round_num),
    .ks_round_key(ks_round_key), .req_valid(req_valid), .req_decrypt(req_decrypt),
    .req_round(req_round), .rsp_valid(rsp_valid), .rsp_key(rsp_key)
  );

  always #5 clk = ~clk;

  // Round r key for key k; the reference DES vector supplies the known endpoints.
  function automatic logic [47:0] ks_fn(input logic [63:0] k, input int r);
    if (k == KNOWN_KEY && r == 1)  return KNOWN_K1;
    if (k == KNOWN_KEY && r == 16) return KNOWN_K16;
    return (k[63:16] ^ k[47:0]) + 48'h9E3779B97F4B * 48'(r);
  endfunction

  // ks stand-in: start presents K1, roundNum n advances to K(n+1), roundNum 0 holds.
  int rk_idx = 0;
  always @(posedge clk) begin
    if (ks_start)                rk_idx <= 1;
    else if (ks_round_num != 0)  rk_idx <= int'(ks_round_num) + 1;
  end
  assign ks_round_key = ks_fn(ks_key, rk_idx);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] key, input int extra_at,
                         input logic [63:0] extra_key, input bit with_req);
    bit exp_v;
    key_in   = key;
    key_load = 1'b1;
    exp_v    = 1'b0;
    if (with_req) begin
      req_valid   = 1'b1;
      req_decrypt = 1'($urandom);
      req_round   = 4'($urandom);
      exp_v       = model_ready;
      if (exp_v) exp_rsp = model_keys[req_decrypt ? 4'd15 - req_round : req_round];
    end
    tick();
    key_load  = 1'b0;
    req_valid = 1'b0;
    key_in    = {$urandom, $urandom};
    model_ready = 1'b0;
    check("load_rsp_valid", rsp_valid, exp_v);
    check("load_rsp_key", rsp_key, exp_rsp);
    if (exp_v) n_rsp++;
    for (int k = 1; k <= 18; k++) begin
      check($sformatf("ks_start@%0d", k), ks_start, k == 1);
      check($sformatf("ks_round_num@%0d", k), ks_round_num,
            (k >= 2 && k <= 16) ? 64'(k - 1) : 64'd0);
      check($sformatf("key_busy@%0d", k), key_busy, k <= 17);
      check($sformatf("keys_ready@%0d", k), keys_ready, k == 18);
      check($sformatf("load_ignored@%0d", k), load_ignored, extra_at >= 0 && k == extra_at + 1);
      check($sformatf("ks_key@%0d", k), ks_key, key);
      if (k == extra_at) begin
        key_load = 1'b1;
        key_in   = extra_key;
      end else begin
        key_load = 1'b0;
      end
      if (k < 18) tick();
    end
    key_load = 1'b0;
    for (int i = 0; i < 16; i++) model_keys[i] = ks_fn(key, i + 1);
    model_ready = 1'b1;
  endtask

  task automatic do_reqs(input int n, input bit all_valid);
    bit v, pv;
    for (int i = 0; i < n; i++) begin
      v           = all_valid ? 1'b1 : 1'($urandom_range(0, 1));
      req_valid   = v;
      req_decrypt = 1'($urandom);
      req_round   = 4'($urandom);
      pv = v && model_ready;
      if (pv) exp_rsp = model_keys[req_decrypt ? 4'd15 - req_round : req_round];
      tick();
      check("rsp_valid", rsp_valid, pv);
      check("rsp_key", rsp_key, exp_rsp);
      if (rsp_valid) n_rsp++;
    end
    req_valid = 1'b0;
    tick();
    check("rsp_valid_idle", rsp_valid, 0);
  endtask

  task automatic req_one(input bit dec, input logic [3:0] rnd, input logic [47:0] exp);
    req_valid   = 1'b1;
    req_decrypt = dec;
    req_round   = rnd;
    tick();
    req_valid = 1'b0;
    exp_rsp   = exp;
    check($sformatf("vec_valid d%0d r%0d", dec, rnd), rsp_valid, 1);
    check($sformatf("vec_key d%0d r%0d", dec, rnd), rsp_key, exp);
  endtask

  task automatic do_abort(input logic [63:0] key);
    key_in   = key;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    repeat (7) tick();
    check("abort_busy", key_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ready = 1'b0;
    exp_rsp     = '0;
    check("abort_keys_ready", keys_ready, 0);
    check("abort_key_busy", key_busy, 0);
    check("abort_ks_start", ks_start, 0);
    check("abort_round_num", ks_round_num, 0);
    check("abort_ks_key", ks_key, 0);
    check("abort_rsp_key", rsp_key, 0);
    repeat (3) tick();
    check("abort_stays_idle", key_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check("rst_load_ignored", load_ignored, 0);
    check("rst_key_busy", key_busy, 0);
    check("rst_keys_ready", keys_ready, 0);
    check("rst_ks_start", ks_start, 0);
    check("rst_ks_key", ks_key, 0);
    check("rst_round_num", ks_round_num, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_key", rsp_key, 0);
    rst = 1'b0;
    tick();
    do_reqs(4, 1'b1);

    do_load(KNOWN_KEY, -1, '0, 1'b0);
    req_one(1'b0, 4'd0,  KNOWN_K1);
    req_one(1'b0, 4'd15, KNOWN_K16);
    req_one(1'b1, 4'd0,  KNOWN_K16);
    req_one(1'b1, 4'd15, KNOWN_K1);
    do_reqs(20, 1'b0);

    do_load({$urandom, $urandom}, 5, {$urandom, $urandom}, 1'b0);
    do_reqs(20, 1'b0);

    do_abort({$urandom, $urandom});
    do_reqs(6, 1'b1);
    do_load(KNOWN_KEY, -1, '0, 1'b0);
    req_one(1'b1, 4'd0, KNOWN_K16);

    do_load({$urandom, $urandom}, -1, '0, 1'b1);
    n_rsp = 0;
    do_reqs(16, 1'b1);
    check("back_to_back_rsps", 64'(n_rsp), 16);

    repeat (3) begin
      do_load({$urandom, $urandom}, -1, '0, 1'b1);
      do_reqs(24, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
